// File: rtl/dma_copy32_pkg.sv
`default_nettype none
// dma_copy32_pkg -- register map, CTRL/STATUS bit positions and FSM encodings for dma_copy32.
// Rev 1.0
package dma_copy32_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR_DONE = 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RGAP = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WGAP = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;

  localparam logic [3:0] WREN_RD = 4'h0;
  localparam logic [3:0] WREN_WR = 4'hF;

  // STATUS layout: [0] busy, [1] done, [2] aborted, [31:16] remaining words
  function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                              input logic aborted, input logic [15:0] rem);
    return {rem, 13'd0, aborted, done, busy};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_copy32.sv
`default_nettype none
// dma_copy32 -- word-granular memory-to-memory copy engine: MMIO-programmed, bus initiator.
// Rev 1.0
module dma_copy32
  import dma_copy32_pkg::*;
#(
  parameter int LEN_W = 14
) (
  input  logic        clk_i,
  input  logic        n_reset_i,
  input  logic        cs_i,
  input  logic [1:0]  reg_adr_i,
  input  logic        wren_i,
  input  logic [31:0] di_i,
  output logic [31:0] do_o,
  output logic        m_op_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_do_o,
  output logic [3:0]  m_wren_o,
  input  logic [31:0] m_di_i,
  input  logic        m_rdy_i,
  input  logic        m_hold_i,
  output logic        irq_o
);

  logic [2:0]       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      buf_q, buf_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             abort_pend_q, abort_pend_d;
  logic             m_op_q, m_op_d;
  logic [31:0]      m_adr_q, m_adr_d;
  logic [31:0]      m_do_q, m_do_d;
  logic [3:0]       m_wren_q, m_wren_d;
  logic [31:0]      do_q, do_d;

  logic busy, rd_req, wr_req, ctrl_wr, start_wr, abort_wr, clr_wr, abort_now, fin_now;

  assign busy      = (state_q != ST_IDLE);
  assign rd_req    = cs_i & ~wren_i;
  assign wr_req    = cs_i & wren_i;
  assign ctrl_wr   = wr_req & (reg_adr_i == REG_CTRL);
  assign start_wr  = ctrl_wr & di_i[CTRL_START];
  assign abort_wr  = ctrl_wr & di_i[CTRL_ABORT];
  assign clr_wr    = ctrl_wr & di_i[CTRL_CLR_DONE];
  assign abort_now = abort_wr | abort_pend_q;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    buf_d        = buf_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    m_op_d       = m_op_q;
    m_adr_d      = m_adr_q;
    m_do_d       = m_do_q;
    m_wren_d     = m_wren_q;
    do_d         = '0;
    fin_now      = 1'b0;

    if (rd_req) begin
      case (reg_adr_i)
        REG_SRC: do_d = src_q;
        REG_DST: do_d = dst_q;
        REG_LEN: do_d = 32'(len_q);
        default: do_d = pack_status(busy, done_q, aborted_q, 16'(len_q));
      endcase
    end

    if (wr_req && !busy) begin
      case (reg_adr_i)
        REG_SRC: src_d = {di_i[31:2], 2'b00};
        REG_DST: dst_d = {di_i[31:2], 2'b00};
        REG_LEN: len_d = di_i[LEN_W-1:0];
        default: ;
      endcase
    end

    if (clr_wr)   done_d       = 1'b0;
    if (abort_wr) abort_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (abort_wr) begin
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (start_wr) begin
          aborted_d = 1'b0;
          if (len_q != '0) begin
            state_d = ST_RGAP;
            done_d  = 1'b0;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      // Abort lands here before a new request starts; hold only delays the start.
      ST_RGAP, ST_WGAP: begin
        if (abort_now) begin
          fin_now = 1'b1;
        end else if (!m_hold_i) begin
          m_op_d = 1'b1;
          if (state_q == ST_RGAP) begin
            state_d  = ST_RD;
            m_adr_d  = src_q;
            m_wren_d = WREN_RD;
          end else begin
            state_d  = ST_WR;
            m_adr_d  = dst_q;
            m_do_d   = buf_q;
            m_wren_d = WREN_WR;
          end
        end
      end
      ST_RD: begin
        if (m_rdy_i) begin
          buf_d   = m_di_i;
          m_op_d  = 1'b0;
          state_d = ST_WGAP;
        end
      end
      ST_WR: begin
        if (m_rdy_i) begin
          src_d    = src_q + 32'd4;
          dst_d    = dst_q + 32'd4;
          len_d    = len_q - LEN_W'(1);
          m_op_d   = 1'b0;
          m_wren_d = WREN_RD;
          if ((len_q == LEN_W'(1)) || abort_now) fin_now = 1'b1;
          else                                    state_d = ST_RGAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin_now) begin
      state_d      = ST_IDLE;
      done_d       = 1'b1;
      aborted_d    = abort_now;
      abort_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_reset_i) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      buf_q        <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      m_op_q       <= 1'b0;
      m_adr_q      <= '0;
      m_do_q       <= '0;
      m_wren_q     <= '0;
      do_q         <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      buf_q        <= buf_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      m_op_q       <= m_op_d;
      m_adr_q      <= m_adr_d;
      m_do_q       <= m_do_d;
      m_wren_q     <= m_wren_d;
      do_q         <= do_d;
    end
  end

  assign do_o     = do_q;
  assign m_op_o   = m_op_q;
  assign m_adr_o  = m_adr_q;
  assign m_do_o   = m_do_q;
  assign m_wren_o = m_wren_q;
  assign irq_o    = done_q;

endmodule
`default_nettype wire
